// File: rtl/satd_seq_ctrl.sv
// satd_seq_ctrl: sequences row load, difference, horizontal/vertical Hadamard and accumulate enables for one SATD block
module satd_seq_ctrl #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int H_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       row_valid,
  input  logic       done_ack,
  output logic       row_ready,
  output logic       load_en,
  output logic       diff_en,
  output logic       hadh_en,
  output logic       hadv_en,
  output logic       acc_en,
  output logic       acc_clr,
  output logic [2:0] row_idx,
  output logic [2:0] count,
  output logic [2:0] state,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, DIFF = 3'd2, HADH = 3'd3, VERT = 3'd4, DONE = 3'd5} st_t;
  localparam logic [2:0] H_LAST = 3'(H_STAGES - 1);
  localparam logic [2:0] R_LAST = 3'(ROWS - 1);
  localparam logic [2:0] C_LAST = 3'(COLS - 1);
  st_t st;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st      <= IDLE;
      row_idx <= '0;
      count   <= '0;
      acc_clr <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      if (abort && st != IDLE) begin
        st      <= IDLE;
        row_idx <= '0;
        count   <= '0;
      end else begin
        case (st)
          IDLE: if (start) begin
            st      <= LOAD;
            row_idx <= '0;
            count   <= '0;
            acc_clr <= 1'b1;
          end
          LOAD: if (row_valid) st <= DIFF;
          DIFF: begin
            st    <= HADH;
            count <= '0;
          end
          HADH: if (count == H_LAST) begin
            count <= '0;
            if (row_idx == R_LAST) st <= VERT;
            else begin
              st      <= LOAD;
              row_idx <= row_idx + 3'd1;
            end
          end else count <= count + 3'd1;
          VERT: if (count == C_LAST) begin
            st    <= DONE;
            count <= '0;
          end else count <= count + 3'd1;
          DONE: if (done_ack) begin
            st      <= start ? LOAD : IDLE;
            row_idx <= '0;
            count   <= '0;
            acc_clr <= start;
          end
          default: st <= IDLE;
        endcase
      end
    end
  assign state     = st;
  assign row_ready = st == LOAD;
  assign load_en   = row_valid & row_ready;
  assign diff_en   = st == DIFF;
  assign hadh_en   = st == HADH;
  assign hadv_en   = st == VERT;
  assign acc_en    = st == VERT;
  assign done      = st == DONE;
  assign busy      = st != IDLE && st != DONE;
endmodule

// File: tb/tb_satd_seq_ctrl.sv
// tb_satd_seq_ctrl: directed scenarios plus randomized run against a position-based block model
module tb_satd_seq_ctrl;
  localparam int R = 8, C = 8, H = 3;
  localparam int RL = 2 + H;
  localparam int TOT = R * RL + C;
  localparam int DONE_CYC = 1 + R * RL + C;
  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, row_valid = 1'b0, done_ack = 1'b0;
  logic row_ready, load_en, diff_en, hadh_en, hadv_en, acc_en, acc_clr, busy, done;
  logic [2:0] row_idx, count, state;
  int passed = 0, total = 0, cyc = 0;
  int m_mode = 0, m_pos = 0;
  logic m_clr = 1'b0;

  satd_seq_ctrl #(.ROWS(R), .COLS(C), .H_STAGES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .row_valid(row_valid),
    .done_ack(done_ack), .row_ready(row_ready), .load_en(load_en), .diff_en(diff_en),
    .hadh_en(hadh_en), .hadv_en(hadv_en), .acc_en(acc_en), .acc_clr(acc_clr),
    .row_idx(row_idx), .count(count), .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // model: m_mode 0 idle, 1 running at step m_pos of the block, 2 result held
  function automatic logic [2:0] exp_state();
    if (m_mode == 0) return 3'd0;
    if (m_mode == 2) return 3'd5;
    if (m_pos >= R * RL) return 3'd4;
    return (m_pos % RL == 0) ? 3'd1 : (m_pos % RL == 1) ? 3'd2 : 3'd3;
  endfunction

  function automatic logic [2:0] exp_row();
    if (m_mode == 0) return 3'd0;
    if (m_mode == 2 || m_pos >= R * RL) return 3'(R - 1);
    return 3'(m_pos / RL);
  endfunction

  function automatic logic [2:0] exp_count();
    if (m_mode != 1) return 3'd0;
    if (m_pos >= R * RL) return 3'(m_pos - R * RL);
    return (m_pos % RL >= 2) ? 3'(m_pos % RL - 2) : 3'd0;
  endfunction

  function automatic logic [18:0] exp_vec(input logic rv);
    logic [2:0] s;
    s = exp_state();
    return {s, exp_row(), exp_count(), s == 3'd1, s == 3'd1 && rv, s == 3'd2, s == 3'd3,
            s == 3'd4, s == 3'd4, m_clr, s != 3'd0 && s != 3'd5, s == 3'd5};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {state, row_idx, count, row_ready, load_en, diff_en, hadh_en, hadv_en, acc_en,
            acc_clr, busy, done};
  endfunction

  task automatic model_step(input logic s, a, rv, da);
    logic clr;
    clr = 1'b0;
    if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_pos = 0; clr = 1'b1; end
    end else if (a) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 1) begin
      if (!(exp_state() == 3'd1 && !rv)) m_pos++;
      if (m_pos == TOT) m_mode = 2;
    end else if (da) begin
      m_mode = s ? 1 : 0; m_pos = 0; clr = s;
    end
    m_clr = clr;
  endtask

  task automatic tick(input logic s, a, rv, da);
    start = s; abort = a; row_valid = rv; done_ack = da;
    @(posedge clk);
    model_step(s, a, rv, da);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (dut_vec() !== 19'd0) $display("FAIL reset_init: got %b expected 0", dut_vec()); else passed++;
    rst = 1'b1;
    tick(1, 0, 1, 0);
    for (int i = 0; i < 200 && !(exp_state() == 3'd4 && exp_count() == 3'd2); i++) tick(0, 0, 1, 0);
    total++;
    if (state !== 3'd4) $display("FAIL reset_reach_vert: got %0d expected 4", state); else passed++;
    #2;
    rst = 1'b0;
    row_valid = 1'b1;
    #1;
    total++;
    if (dut_vec() !== 19'd0) $display("FAIL reset_mid_vert: got %b expected 0", dut_vec()); else passed++;
    m_mode = 0; m_pos = 0; m_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 1);
      total++;
      if (state !== 3'd0 || busy !== 1'b0) $display("FAIL reset_stay_idle: got state %0d busy %0d expected 0 0", state, busy); else passed++;
    end
  endtask

  task automatic test_nominal();
    int nl = 0, nd = 0, nh = 0, na = 0, nc = 0, clr_cyc = -1, dc = -1;
    cyc = 0;
    tick(1, 0, 1, 1);
    for (int i = 0; i < 200 && dc < 0; i++) begin
      row_valid = 1'b1;
      #1;
      nl += int'(load_en); nd += int'(diff_en); nh += int'(hadh_en); na += int'(acc_en);
      if (acc_clr) begin nc++; clr_cyc = cyc; end
      if (done) dc = cyc;
      tick(0, 0, 1, 1);
    end
    total++; if (dc != DONE_CYC) $display("FAIL nominal_done_cycle: got %0d expected %0d", dc, DONE_CYC); else passed++;
    total++; if (nl != R) $display("FAIL nominal_load_en: got %0d expected %0d", nl, R); else passed++;
    total++; if (nd != R) $display("FAIL nominal_diff_en: got %0d expected %0d", nd, R); else passed++;
    total++; if (nh != R * H) $display("FAIL nominal_hadh_en: got %0d expected %0d", nh, R * H); else passed++;
    total++; if (na != C) $display("FAIL nominal_acc_en: got %0d expected %0d", na, C); else passed++;
    total++; if (nc != 1 || clr_cyc != 1) $display("FAIL nominal_acc_clr: got %0d pulses at %0d expected 1 at 1", nc, clr_cyc); else passed++;
    total++; if (state !== 3'd0) $display("FAIL nominal_after_ack: got %0d expected 0", state); else passed++;
  endtask

  task automatic test_stall();
    int stalls = 0, dc = -1;
    cyc = 0;
    tick(1, 0, 1, 0);
    for (int i = 0; i < 200 && dc < 0; i++) begin
      logic rv;
      rv = !(exp_state() == 3'd1 && exp_row() == 3'd3 && stalls < 4);
      row_valid = rv;
      #1;
      if (!rv) begin
        stalls++;
        total++;
        if (state !== 3'd1 || row_idx !== 3'd3 || load_en !== 1'b0)
          $display("FAIL stall_hold: got state %0d row %0d load_en %0d expected 1 3 0", state, row_idx, load_en);
        else passed++;
      end
      if (done) dc = cyc;
      tick(0, 0, rv, 1);
    end
    total++; if (dc != DONE_CYC + 4) $display("FAIL stall_done_cycle: got %0d expected %0d", dc, DONE_CYC + 4); else passed++;
  endtask

  task automatic test_back_to_back();
    int held = 0;
    tick(1, 0, 1, 0);
    for (int i = 0; i < 200 && m_mode != 2; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      held += int'(done === 1'b1 && state === 3'd5);
      tick(0, 0, 1, 0);
    end
    total++; if (held != 3) $display("FAIL b2b_done_held: got %0d cycles expected 3", held); else passed++;
    tick(1, 0, 0, 1);
    total++;
    if (state !== 3'd1 || row_idx !== 3'd0 || acc_clr !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_restart: got state %0d row %0d acc_clr %0d done %0d expected 1 0 1 0", state, row_idx, acc_clr, done);
    else passed++;
    tick(0, 1, 0, 0);
    total++; if (state !== 3'd0) $display("FAIL b2b_abort_cleanup: got %0d expected 0", state); else passed++;
  endtask

  task automatic test_abort();
    int nd = 0;
    tick(1, 0, 1, 0);
    for (int i = 0; i < 200 && !(m_mode == 1 && m_pos == 5 * RL + 3); i++) tick(0, 0, 1, 0);
    total++;
    if (state !== 3'd3 || row_idx !== 3'd5 || count !== 3'd1)
      $display("FAIL abort_reach: got state %0d row %0d count %0d expected 3 5 1", state, row_idx, count);
    else passed++;
    tick(0, 1, 1, 0);
    total++;
    if (state !== 3'd0 || row_idx !== 3'd0 || count !== 3'd0)
      $display("FAIL abort_clear: got state %0d row %0d count %0d expected 0 0 0", state, row_idx, count);
    else passed++;
    for (int i = 0; i < 60; i++) begin
      nd += int'(done);
      tick(0, 0, 1, 1);
    end
    total++; if (nd != 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", nd); else passed++;
  endtask

  task automatic test_ignored();
    int dc = -1, bad = 0;
    cyc = 0;
    tick(1, 0, 1, 0);
    for (int i = 0; i < 200 && dc < 0; i++) begin
      logic s, da;
      s = exp_state() == 3'd2;
      da = exp_state() == 3'd1 || exp_state() == 3'd5;
      #1;
      bad += int'(state !== exp_state() || count !== exp_count() || row_idx !== exp_row());
      if (done) dc = cyc;
      tick(s, 0, 1, da);
    end
    total++; if (dc != DONE_CYC) $display("FAIL ignored_done_cycle: got %0d expected %0d", dc, DONE_CYC); else passed++;
    total++; if (bad != 0) $display("FAIL ignored_sequence: got %0d deviating cycles expected 0", bad); else passed++;
    total++; if (state !== 3'd0) $display("FAIL ignored_final_idle: got %0d expected 0", state); else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      logic s, a, rv, da;
      s = $urandom_range(0, 3) == 0;
      a = $urandom_range(0, 59) == 0;
      rv = $urandom_range(0, 2) != 0;
      da = $urandom_range(0, 2) == 0;
      start = s; abort = a; row_valid = rv; done_ack = da;
      #1;
      total++;
      if (dut_vec() !== exp_vec(rv)) begin
        if (bad < 10) $display("FAIL random_cycle %0d: got %b expected %b", i, dut_vec(), exp_vec(rv));
        bad++;
      end else passed++;
      tick(s, a, rv, da);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_back_to_back();
    test_abort();
    test_ignored();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
